// File: rtl/ram_ctrl_clear.sv
// Parametrised single-port RAM controller with a hardware zero-fill sequencer.
// Read latency is 1 cycle; Ready drops for DEPTH cycles while clearing and all strobes are ignored then.
module ram_ctrl_clear #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  ResetN,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Write,
  input  logic                  Read,
  input  logic                  Clear,
  output logic                  Ready,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  ReadValid,
  output logic                  ClearDone
);

  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clear_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  addr_ok, clear_last, clr_go, wr_go, rd_go;

  // Addresses at or above DEPTH are unmapped: writes dropped, reads return 0.
  assign addr_ok    = ({1'b0, Address} < (ADDR_WIDTH + 1)'(DEPTH));
  assign clear_last = (clear_ptr == LAST_PTR);
  assign clr_go     = (state == IDLE) && Clear;
  assign wr_go      = (state == IDLE) && Write && !Clear;
  assign rd_go      = (state == IDLE) && Read && !Clear;
  assign Ready      = (state == IDLE);

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) state <= CLEARING;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Clear) state_nxt = CLEARING;
      CLEARING: if (clear_last) state_nxt = IDLE;
      default:  state_nxt = CLEARING;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      clear_ptr <= '0;
      DataOut   <= '0;
      ReadValid <= 1'b0;
      ClearDone <= 1'b0;
    end else begin
      ReadValid <= rd_go;
      ClearDone <= (state == CLEARING) && clear_last;
      if (clr_go) begin
        clear_ptr <= '0;
        DataOut   <= '0;
      end else if (state == CLEARING) begin
        clear_ptr <= clear_ptr + 1'b1;
      end else if (rd_go) begin
        // Write-first on a simultaneous read/write of the same word.
        if (!addr_ok)   DataOut <= '0;
        else if (Write) DataOut <= DataIn;
        else            DataOut <= mem[Address];
      end
    end
  end

  // Array has no reset; the clear sequence after reset release zeroes it.
  always_ff @(posedge CLK) begin
    if (state == CLEARING)     mem[clear_ptr] <= '0;
    else if (wr_go && addr_ok) mem[Address]   <= DataIn;
  end

endmodule

// File: tb/tb_ram_ctrl_clear.sv
// Randomised self-checking bench for ram_ctrl_clear against an array-based reference model.
module tb_ram_ctrl_clear;

  localparam int DW = 3;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          CLK = 1'b0;
  logic          ResetN = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] DataIn = '0;
  logic          Write = 1'b0, Read = 1'b0, Clear = 1'b0;
  logic          Ready, ReadValid, ClearDone;
  logic [DW-1:0] DataOut;

  logic          b_ResetN = 1'b0;
  logic [3:0]    b_Address = '0;
  logic [7:0]    b_DataIn = '0;
  logic          b_Write = 1'b0, b_Read = 1'b0, b_Clear = 1'b0;
  logic          b_Ready, b_ReadValid, b_ClearDone;
  logic [7:0]    b_DataOut;

  always #5 CLK = ~CLK;

  ram_ctrl_clear u_dut (
    .CLK(CLK), .ResetN(ResetN), .Address(Address), .DataIn(DataIn),
    .Write(Write), .Read(Read), .Clear(Clear), .Ready(Ready),
    .DataOut(DataOut), .ReadValid(ReadValid), .ClearDone(ClearDone)
  );

  ram_ctrl_clear #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut8 (
    .CLK(CLK), .ResetN(b_ResetN), .Address(b_Address), .DataIn(b_DataIn),
    .Write(b_Write), .Read(b_Read), .Clear(b_Clear), .Ready(b_Ready),
    .DataOut(b_DataOut), .ReadValid(b_ReadValid), .ClearDone(b_ClearDone)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_q = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_q = '0;
  endtask

  // One IDLE-cycle operation; outputs are checked on the following negedge.
  task automatic idle_op(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    Write = wr; Read = rd; Clear = 1'b0; Address = a; DataIn = d;
    if (rd) ref_q = wr ? d : ref_mem[a];
    if (wr) ref_mem[a] = d;
    @(negedge CLK);
    check("readvalid", ReadValid, rd);
    check("dataout", DataOut, ref_q);
    check("ready", Ready, 1);
    check("cleardone", ClearDone, 0);
  endtask

  // Called on the first negedge with Ready=0; measures the clear window.
  task automatic wait_clear(input string tag, input bit poke);
    int cycles = 0, cd = 0, rv = 0, bad = 0;
    while (Ready == 1'b0 && cycles < 200) begin
      if (ClearDone) cd++;
      if (ReadValid) rv++;
      if (DataOut != '0) bad++;
      cycles++;
      if (poke) begin
        Write = 1'($urandom()); Read = 1'($urandom()); Clear = 1'($urandom());
        Address = AW'($urandom()); DataIn = DW'($urandom());
      end
      @(negedge CLK);
    end
    Write = 1'b0; Read = 1'b0; Clear = 1'b0;
    check({tag, "_cycles"}, cycles, DEPTH);
    check({tag, "_cd_early"}, cd, 0);
    check({tag, "_cd_pulse"}, ClearDone, 1);
    check({tag, "_rv_during"}, rv, 0);
    check({tag, "_dout_during"}, bad, 0);
    model_zero();
  endtask

  task automatic do_clear(input string tag, input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    Write = wr; Read = rd; Clear = 1'b1; Address = a; DataIn = d;
    @(negedge CLK);
    check({tag, "_entry_ready"}, Ready, 0);
    check({tag, "_entry_dout"}, DataOut, 0);
    check({tag, "_entry_rv"}, ReadValid, 0);
    wait_clear(tag, 1'b1);
  endtask

  task automatic readback_all();
    for (int a = 0; a < DEPTH; a++) idle_op(1'b0, 1'b1, AW'(a), '0);
  endtask

  initial begin
    // Reset values and the post-reset clear
    repeat (3) @(negedge CLK);
    check("rst_ready", Ready, 0);
    check("rst_dout", DataOut, 0);
    check("rst_rv", ReadValid, 0);
    check("rst_cd", ClearDone, 0);
    ResetN = 1'b1;
    wait_clear("init", 1'b0);
    readback_all();

    // Simple write/read, untouched neighbour, write-first
    idle_op(1'b1, 1'b0, 5'd1, 3'd4);
    idle_op(1'b0, 1'b1, 5'd1, 3'd0);
    idle_op(1'b0, 1'b0, 5'd0, 3'd0);
    idle_op(1'b0, 1'b1, 5'd2, 3'd0);
    idle_op(1'b1, 1'b1, 5'd2, 3'd5);
    idle_op(1'b0, 1'b1, 5'd2, 3'd0);

    // Fill, then clear with a colliding write and strobes during clearing
    for (int a = 0; a < DEPTH; a++) idle_op(1'b1, 1'b0, AW'(a), 3'd7);
    do_clear("clr", 1'b1, 1'b1, 5'd3, 3'd6);
    readback_all();

    // Reset at cycle 10 of a clear sequence
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    repeat (9) @(negedge CLK);
    ResetN = 1'b0;
    #1;
    check("midrst_ready", Ready, 0);
    check("midrst_dout", DataOut, 0);
    check("midrst_rv", ReadValid, 0);
    check("midrst_cd", ClearDone, 0);
    @(negedge CLK);
    ResetN = 1'b1;
    wait_clear("midrst", 1'b0);

    // Randomised traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0)
        do_clear("rclr", 1'($urandom()), 1'($urandom()), AW'($urandom()), DW'($urandom()));
      else
        idle_op(1'($urandom()), 1'($urandom()), AW'($urandom()), DW'($urandom()));
    end
    readback_all();

    // Second instance: 8-bit data, 16 words
    check("b_rst_ready", b_Ready, 0);
    check("b_rst_dout", b_DataOut, 0);
    b_ResetN = 1'b1;
    begin
      int cycles = 0, cd = 0;
      while (b_Ready == 1'b0 && cycles < 100) begin
        if (b_ClearDone) cd++;
        cycles++;
        @(negedge CLK);
      end
      check("b_cycles", cycles, 16);
      check("b_cd_early", cd, 0);
      check("b_cd_pulse", b_ClearDone, 1);
    end
    b_Address = 4'd7; b_Read = 1'b1;
    @(negedge CLK);
    check("b_rd7_dout", b_DataOut, 8'h00);
    check("b_rd7_rv", b_ReadValid, 1);
    b_Address = 4'd15; b_DataIn = 8'hA5; b_Write = 1'b1; b_Read = 1'b0;
    @(negedge CLK);
    check("b_wr_rv", b_ReadValid, 0);
    b_Write = 1'b0; b_Read = 1'b1;
    @(negedge CLK);
    b_Read = 1'b0;
    check("b_rd15_dout", b_DataOut, 8'hA5);
    check("b_rd15_rv", b_ReadValid, 1);
    @(negedge CLK);
    check("b_rv_drop", b_ReadValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
